// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 multi-requester scheduler.
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_NEXT,
    ST_DRAIN
  } sched_state_e;

  localparam int TIMEOUT_DEF = 255;
  localparam int BLOCK_BITS  = 512;
  localparam int WDOG_W      = 8;

endpackage

// File: rtl/sha256_scheduler_if.sv
// Requester-side and core-side signal bundle of the scheduler.
// master: the scheduler itself; slave: requesters plus core.
interface sha256_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] req_first;
  logic [N_REQ-1:0] req_last;
  logic [N_REQ-1:0] blk_ack;
  logic [ID_W-1:0]  sel;
  logic             lock;
  logic             core_start;
  logic             core_first;
  logic             core_last;
  logic             core_busy;
  logic             core_done;
  logic             core_out_en;
  logic [N_REQ-1:0] dig_valid;
  logic             timeout_err;

  modport master (
    input  req, req_first, req_last, core_busy, core_done, core_out_en,
    output blk_ack, sel, lock, core_start, core_first, core_last,
           dig_valid, timeout_err
  );

  modport slave (
    output req, req_first, req_last, core_busy, core_done, core_out_en,
    input  blk_ack, sel, lock, core_start, core_first, core_last,
           dig_valid, timeout_err
  );
endinterface

// File: rtl/sha256_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i,
// wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [ID_W-1:0]  grant_o,
  output logic             valid_o
);

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    grant_o = '0;
    valid_o = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_i} + (ID_W + 1)'(k);
      if (sum >= (ID_W + 1)'(N_REQ)) sum = sum - (ID_W + 1)'(N_REQ);
      idx = sum[ID_W-1:0];
      if (req_i[idx]) begin
        grant_o = idx;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sha256_scheduler.sv
// Scheduler for the shared SHA-256 core: round-robin message ownership,
// per-block start/first/last sequencing, digest-window routing, watchdog.
module sha256_scheduler
  import sha256_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = $clog2(N_REQ),
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic                clk,
  input logic                reset_n,
  sha256_scheduler_if.master bus
);

  sched_state_e      state_q, state_d;
  logic [ID_W-1:0]   sel_q, sel_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              lock_q, lock_d;
  logic              first_q, first_d;   // next issued block is the message's first
  logic              last_q, last_d;     // block in flight was the message's last
  logic              rise_q, rise_d;     // core_out_en rise seen while draining
  logic              err_q, err_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  logic [ID_W-1:0]   grant;
  logic              grant_vld;
  logic [ID_W-1:0]   nxt_ptr;
  logic              wdog_hit;
  logic [N_REQ-1:0]  ack;
  logic              start, start_first, start_last;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req_i   (bus.req & bus.req_first),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .valid_o (grant_vld)
  );

  assign nxt_ptr  = (sel_q == ID_W'(N_REQ - 1)) ? '0 : sel_q + 1'b1;
  assign wdog_hit = (wdog_q == WDOG_W'(TIMEOUT - 1));

  // State and bookkeeping registers; async reset abandons any message.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      lock_q   <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      rise_q   <= 1'b0;
      err_q    <= 1'b0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      lock_q   <= lock_d;
      first_q  <= first_d;
      last_q   <= last_d;
      rise_q   <= rise_d;
      err_q    <= err_d;
      wdog_q   <= wdog_d;
    end
  end

  // Next-state logic plus the decoded start/ack strobes.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rr_ptr_d    = rr_ptr_q;
    lock_d      = lock_q;
    first_d     = first_q;
    last_d      = last_q;
    rise_d      = rise_q;
    err_d       = err_q;
    wdog_d      = wdog_q;
    ack         = '0;
    start       = 1'b0;
    start_first = 1'b0;
    start_last  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          sel_d   = grant;
          lock_d  = 1'b1;
          first_d = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!bus.core_busy && bus.req[sel_q]) begin
          start       = 1'b1;
          ack[sel_q]  = 1'b1;
          start_first = first_q;
          start_last  = bus.req_last[sel_q];
          last_d      = bus.req_last[sel_q];
          first_d     = 1'b0;
          wdog_d      = '0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The awaited event takes priority over an expiring watchdog.
        if (bus.core_done) begin
          wdog_d  = '0;
          rise_d  = bus.core_out_en;
          state_d = last_q ? ST_DRAIN : ST_NEXT;
        end else if (wdog_hit) begin
          err_d    = 1'b1;
          lock_d   = 1'b0;
          rr_ptr_d = nxt_ptr;
          state_d  = ST_IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ST_NEXT: begin
        if (bus.req[sel_q]) state_d = ST_ISSUE;
      end
      ST_DRAIN: begin
        if (rise_q && !bus.core_out_en) begin
          lock_d   = 1'b0;
          rr_ptr_d = nxt_ptr;
          state_d  = ST_IDLE;
        end else if (wdog_hit) begin
          err_d    = 1'b1;
          lock_d   = 1'b0;
          rr_ptr_d = nxt_ptr;
          state_d  = ST_IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
          if (bus.core_out_en) rise_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.sel         = sel_q;
  assign bus.lock        = lock_q;
  assign bus.timeout_err = err_q;
  assign bus.blk_ack     = ack;
  assign bus.core_start  = start;
  assign bus.core_first  = start_first;
  assign bus.core_last   = start_last;
  assign bus.dig_valid   = lock_q ? (N_REQ'(bus.core_out_en) << sel_q) : '0;

endmodule
